// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed big-endian memory with fixed wait states and four-phase handshake
//
// Purpose:
//   Responds to single memory requests after WAIT_CYCLES wait states. Each
//   request is captured on acceptance and completes with moc held high until
//   the initiator drops mov. Illegal requests complete with err = 1 and touch
//   no storage.
//
// Parameters:
//   WAIT_CYCLES  wait states between acceptance and completion (1..15)
//   DEPTH_BYTES  storage size in bytes
//
// Ports:
//   clk       in   rising-edge clock
//   clr       in   asynchronous active-low reset
//   mov       in   request valid, held for the whole request
//   rw        in   1 = read, 0 = write
//   dtype     in   00 byte, 01 halfword, 10 word, 11 reserved
//   sign      in   sign-extend byte/halfword reads
//   addr      in   byte address
//   data_in   in   write data, right-justified
//   data_out  out  read data, right-justified (0 for writes and errors)
//   moc       out  operation complete
//   err       out  request rejected, only meaningful while moc = 1

module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  dtype,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        err
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        err_q, err_d;
  logic        capture;

  // Captured request; inputs are ignored once the request is accepted.
  logic        rw_q;
  logic [1:0]  dtype_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [2:0]  size_b;
  logic [32:0] last_byte;
  logic        req_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rdata;
  logic        access;
  logic        we;

  always_comb begin
    case (dtype_q)
      2'b00:   size_b = 3'd1;
      2'b01:   size_b = 3'd2;
      2'b10:   size_b = 3'd4;
      default: size_b = 3'd1;
    endcase
  end

  // 33-bit sum so addresses near 0xFFFFFFFF cannot wrap into range.
  assign last_byte = {1'b0, addr_q} + {30'd0, size_b} - 33'd1;

  assign req_err = (dtype_q == 2'b11)
                 || ((dtype_q == 2'b01) && addr_q[0])
                 || ((dtype_q == 2'b10) && (addr_q[1:0] != 2'b00))
                 || (last_byte >= 33'(DEPTH_BYTES));

  assign idx0 = addr_q[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  // Out-of-range indices only occur on error requests, whose data is discarded.
  assign b0 = mem[idx0];
  assign b1 = mem[idx1];
  assign b2 = mem[idx2];
  assign b3 = mem[idx3];

  always_comb begin
    case (dtype_q)
      2'b00:   rdata = {{24{sign_q & b0[7]}}, b0};
      2'b01:   rdata = {{16{sign_q & b0[7]}}, b0, b1};
      2'b10:   rdata = {b0, b1, b2, b3};
      default: rdata = 32'd0;
    endcase
  end

  assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign we     = access && !rw_q && !req_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mov) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          err_d   = req_err;
          dout_d  = (rw_q && !req_err) ? rdata : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // Leave only once mov is seen low, so a held mov cannot retrigger.
        if (!mov) begin
          state_d = S_IDLE;
          dout_d  = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        dout_d  = 32'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      dtype_q <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      if (capture) begin
        rw_q    <= rw;
        dtype_q <= dtype;
        sign_q  <= sign;
        addr_q  <= addr;
        wdata_q <= data_in;
      end
    end
  end

  // Storage has no reset; a reset in WAIT leaves state_q at IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (we) begin
      case (dtype_q)
        2'b00: begin
          mem[idx0] <= wdata_q[7:0];
        end
        2'b01: begin
          mem[idx0] <= wdata_q[15:8];
          mem[idx1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem[idx0] <= wdata_q[31:24];
          mem[idx1] <= wdata_q[23:16];
          mem[idx2] <= wdata_q[15:8];
          mem[idx3] <= wdata_q[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign err      = err_q;
  assign moc      = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder

module tb_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        clr;
  logic        mov;
  logic        rw;
  logic [1:0]  dtype;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        err;

  int n_cmp;
  int n_fail;
  int n_rises;
  logic        moc_prev;
  logic [31:0] hold_d;
  logic        hold_e;
  logic [32:0] exp_q[$];

  mem_responder #(.WAIT_CYCLES(W), .DEPTH_BYTES(256)) dut (
    .clk      (clk),
    .clr      (clr),
    .mov      (mov),
    .rw       (rw),
    .dtype    (dtype),
    .sign     (sign),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per moc rising edge, checks hold stability.
  always @(negedge clk) begin
    logic [32:0] e;
    if (moc && !moc_prev) begin
      n_rises++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_moc: got data %h err %0d expected no completion", data_out, err);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e[31:0]);
        check("err", {31'd0, err}, {31'd0, e[32]});
      end
      hold_d = data_out;
      hold_e = err;
    end else if (moc && moc_prev) begin
      if (data_out !== hold_d || err !== hold_e) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_hold: got %h/%0d expected %h/%0d", data_out, err, hold_d, hold_e);
      end
    end
    if (err && !moc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL err_without_moc: got err %0d expected 0", err);
    end
    moc_prev = moc;
  end

  // mode 0 normal, 1 scramble inputs in WAIT, 2 drop mov in WAIT, 3 hold mov 5 cycles in DONE
  task automatic req(input logic r, input logic [1:0] dt, input logic sg, input logic [31:0] ad,
                     input logic [31:0] din, input logic [31:0] expd, input logic experr, input int mode);
    int cyc;
    int hi;
    int rise0;
    logic got;
    exp_q.push_back({experr, expd});
    rise0   = n_rises;
    rw      = r;
    dtype   = dt;
    sign    = sg;
    addr    = ad;
    data_in = din;
    mov     = 1'b1;
    cyc     = 0;
    got     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && mode == 1) begin
        rw      = ~rw;
        dtype   = ~dtype;
        sign    = ~sign;
        addr    = $urandom;
        data_in = $urandom;
      end
      if (cyc == 1 && mode == 2) mov = 1'b0;
      if (moc) begin
        got = 1'b1;
        break;
      end
    end
    check("moc_seen", {31'd0, got}, 32'd1);
    check("latency", 32'(cyc - 1), 32'(W));
    if (mode == 2) begin
      @(posedge clk);
      #1;
      check("moc_pulse_one_cycle", {31'd0, moc}, 32'd0);
    end
    if (mode == 3) begin
      hi = 0;
      repeat (5) begin
        @(posedge clk);
        #1;
        if (moc) hi++;
      end
      check("moc_held_cycles", 32'(hi), 32'd5);
    end
    mov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!moc) break;
      @(posedge clk);
      #1;
    end
    check("moc_released", {31'd0, moc}, 32'd0);
    check("one_transaction", 32'(n_rises - rise0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int rise0;
    n_cmp = 0; n_fail = 0; n_rises = 0; moc_prev = 1'b0;
    hold_d = 32'd0; hold_e = 1'b0;
    mov = 1'b0; rw = 1'b0; dtype = 2'b00; sign = 1'b0; addr = 32'd0; data_in = 32'd0;
    clr = 1'b1;
    #2 clr = 1'b0;
    #2;
    check("rst_moc", {31'd0, moc}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", data_out, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b1;

    req(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    req(1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAD, 1'b0, 0);
    req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 32'h000000AD, 1'b0, 0);
    req(1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
    req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 0);
    req(1'b1, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    req(1'b1, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000DEAD, 1'b0, 0);
    req(1'b1, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    req(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0, 0);

    req(1'b0, 2'b00, 1'b0, 32'h13, 32'hAABBCC55, 32'h0, 1'b0, 0);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 0);
    req(1'b0, 2'b10, 1'b0, 32'h14, 32'h01020304, 32'h0, 1'b0, 0);
    req(1'b0, 2'b01, 1'b0, 32'h16, 32'hFFFF9988, 32'h0, 1'b0, 0);
    req(1'b1, 2'b10, 1'b0, 32'h14, 32'h0, 32'h01029988, 1'b0, 0);
    req(1'b1, 2'b01, 1'b1, 32'h14, 32'h0, 32'h00000102, 1'b0, 0);

    req(1'b0, 2'b10, 1'b0, 32'h13, 32'h11223344, 32'h0, 1'b1, 0);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 0);
    req(1'b1, 2'b01, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    req(1'b0, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 0);

    req(1'b0, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    req(1'b1, 2'b10, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    req(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0, 32'h0000000D, 1'b0, 0);
    req(1'b1, 2'b01, 1'b1, 32'hFE, 32'h0, 32'hFFFFF00D, 1'b0, 0);
    req(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    req(1'b1, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 0);

    req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0BADF00D, 32'h0, 1'b0, 1);
    req(1'b1, 2'b10, 1'b0, 32'h18, 32'h0, 32'h0BADF00D, 1'b0, 1);
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 3);
    req(1'b1, 2'b00, 1'b0, 32'h14, 32'h0, 32'h00000001, 1'b0, 2);

    req(1'b0, 2'b10, 1'b0, 32'h20, 32'hA1B2C3D4, 32'h0, 1'b0, 0);
    rise0   = n_rises;
    rw      = 1'b0;
    dtype   = 2'b10;
    sign    = 1'b0;
    addr    = 32'h20;
    data_in = 32'h12345678;
    mov     = 1'b1;
    @(posedge clk);
    #3 clr = 1'b0;
    #1;
    check("abort_moc", {31'd0, moc}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_data", data_out, 32'd0);
    mov = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_completion", 32'(n_rises - rise0), 32'd0);
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA1B2C3D4, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving wait states before completion (legal 1..15).
REQ-002 The block SHALL have parameter DEPTH_BYTES, default 256, giving byte-addressed storage size.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 clr  input  1  asynchronous active-low reset.
REQ-006 mov  input  1  memory operation valid, held high by the initiator for the whole request.
REQ-007 rw  input  1  1 = read, 0 = write.
REQ-008 dtype  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 sign  input  1  read sign-extension enable.
REQ-010 addr  input  32  byte address.
REQ-011 data_in  input  32  write data, right-justified.
REQ-012 data_out  output  32  read data, right-justified.
REQ-013 moc  output  1  memory operation complete.
REQ-014 err  output  1  request rejected, valid while moc = 1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-016 In IDLE with mov = 1 at a rising edge, the block SHALL capture rw, dtype, sign, addr and data_in, load the counter with WAIT_CYCLES-1, and enter WAIT.
REQ-017 In WAIT, the block SHALL decrement the counter each edge; when the counter is 0 it SHALL perform the access and enter DONE on that edge.
REQ-018 Inputs changing after capture SHALL have no effect on the transaction in progress.
REQ-019 moc SHALL be 1 only in DONE; if mov is sampled high at edge N, moc SHALL rise after edge N+WAIT_CYCLES.
REQ-020 DONE SHALL hold moc, data_out and err stable until mov is sampled 0, then return to IDLE with moc = 0 (four-phase handshake).
REQ-021 A new request SHALL NOT be accepted until IDLE is re-entered; mov still high in DONE SHALL NOT start a second transaction.
REQ-022 If mov drops during WAIT, the transaction SHALL still complete; moc SHALL pulse for exactly one cycle in DONE, then the block returns to IDLE.
REQ-023 Storage SHALL be big-endian: the most significant byte of a word is at the lowest address.
REQ-024 A byte read SHALL return mem[addr] in bits 7:0.
REQ-025 A halfword read SHALL return {mem[addr], mem[addr+1]} in bits 15:0.
REQ-026 A word read SHALL return four bytes from addr.
REQ-027 For byte and halfword reads, upper bits SHALL equal the data MSB when sign = 1 and SHALL be 0 when sign = 0; sign SHALL be ignored for word reads.
REQ-028 A write SHALL store the low 8, 16 or 32 bits of data_in big-endian at addr, SHALL change no other byte, and SHALL drive data_out = 0 in DONE.
REQ-029 Error condition: dtype = 11, halfword with addr[0] = 1, word with addr[1:0] != 00, or addr+size-1 >= DEPTH_BYTES.
REQ-030 On an error condition the block SHALL modify no storage, SHALL drive data_out = 0 and err = 1 in DONE, and SHALL keep the same latency and handshake.
REQ-031 err SHALL be 0 whenever moc = 0.

Reset
REQ-032 Assertion of clr (low) SHALL immediately force state IDLE, moc = 0, err = 0, data_out = 0, counter = 0, and clear the captured request.
REQ-033 Reset during WAIT SHALL abort the access: a pending write SHALL NOT be committed.
REQ-034 Storage contents SHALL NOT be altered by reset.
REQ-035 After clr deasserts, the first rising edge with mov = 1 SHALL start a new transaction per REQ-016.

Verification
REQ-036 Word write 0xDEADBEEF to 0x10, WAIT_CYCLES = 2 -> moc rises exactly 2 edges after mov is sampled, err = 0, mem[0x10..0x13] = DE AD BE EF.
REQ-037 Byte reads of 0x11: sign = 1 -> 0xFFFFFFAD; sign = 0 -> 0x000000AD.
REQ-038 Halfword read of 0x12 with sign = 1 -> 0xFFFFBEEF; word read of 0x10 -> 0xDEADBEEF.
REQ-039 Misaligned requests -> err = 1, data_out = 0, moc asserts with normal latency, storage unchanged:
- word write at 0x13;
- halfword read at 0x11;
- dtype = 11 at 0x10.
REQ-040 Handshake corner cases:
- mov held high 5 cycles after moc -> exactly one transaction;
- mov dropped in WAIT -> one-cycle moc pulse.
REQ-041 Reset pulse during WAIT of a write of 0x12345678 to 0x20 -> moc stays 0, mem[0x20..0x23] unchanged; the next read of 0x20 succeeds.
